// File: rtl/aes_slot_scheduler_pkg.sv
// Shared constants and helpers for the AES-128 slot scheduler.
// Contents:
//   AES_ROUNDS              rounds per AES-128 block
//   RND_LOAD/FINAL/DRAIN    per-slot round encodings (load visit, final round, retire)
//   rcon()                  round constant for rounds 1..10 (0 elsewhere)
package aes_slot_scheduler_pkg;

    localparam int unsigned AES_ROUNDS = 10;

    localparam logic [3:0] RND_LOAD  = 4'd1;
    localparam logic [3:0] RND_FINAL = 4'd10;
    localparam logic [3:0] RND_DRAIN = 4'd11;

    // AES key-schedule round constant for round r (1-based)
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1B;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_slot_scheduler_arbiter.sv
// Round-robin arbiter: picks the lowest-index active request at or above ptr,
// wrapping to the lowest active request below ptr.
// Ports:
//   req        in   N_REQ   request vector
//   ptr        in   IDX_W   round-robin start index (0..N_REQ-1)
//   gnt_c      out  N_REQ   one-hot grant (zero if no request)
//   gnt_idx_c  out  IDX_W   index of granted request
//   gnt_any_c  out  1       at least one request active
module aes_rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0] gnt_idx_c,
    output logic             gnt_any_c
);

    logic [N_REQ-1:0] mask_hi;
    logic [N_REQ-1:0] cand;
    logic             found;

    // Requests at/above ptr take priority; fall back to the full vector on wrap
    always_comb begin
        mask_hi = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            mask_hi[i] = (IDX_W'(i) >= ptr);
        end
        cand = ((req & mask_hi) != '0) ? (req & mask_hi) : req;
    end

    // Lowest set bit of the candidate vector
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && cand[i]) begin
                found     = 1'b1;
                gnt_c[i]  = 1'b1;
                gnt_idx_c = IDX_W'(i);
            end
        end
        gnt_any_c = |req;
    end

endmodule

// File: rtl/aes_slot_scheduler.sv
// Time-slot scheduler for a fully pipelined masked AES-128 core. The round
// loop holds SBOX_LATENCY interleaved blocks, one per pipeline stage; slot_ptr
// names the slot currently entering stage 0. Free slots are filled round-robin
// from N_REQ requesters, and each busy slot's round counter drives the core
// key/Rcon/final controls until the block retires with its requester tag.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    per-requester block ready
//   req_ready    one-hot grant (block loaded this cycle)
//   core_load    stage 0 takes a new block, core_sel selects the requester
//   core_rcon    Rcon for the slot entering stage 0
//   core_final   slot entering stage 0 runs the final round
//   core_keyen   advance round key of the slot entering stage 0
//   res_valid    one-cycle pulse, finished ciphertext at core output
//   res_tag      requester index of the finished block
//   idle         no slot busy
module aes_slot_scheduler
    import aes_slot_scheduler_pkg::*;
#(
    parameter  int unsigned SBOX_LATENCY = 5,
    parameter  int unsigned N_REQ        = 4,
    parameter  int unsigned N_ROUNDS     = AES_ROUNDS,
    localparam int unsigned IDX_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned SLOT_W       = (SBOX_LATENCY > 1) ? $clog2(SBOX_LATENCY) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    output logic             core_load,
    output logic [IDX_W-1:0] core_sel,
    output logic [7:0]       core_rcon,
    output logic             core_final,
    output logic             core_keyen,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_tag,
    output logic             idle
);

    // AES-128 always runs 10 rounds; a different N_ROUNDS only moves the markers
    localparam logic [3:0] RND_FIN = (N_ROUNDS == AES_ROUNDS) ? RND_FINAL : 4'(N_ROUNDS);
    localparam logic [3:0] RND_DRN = (N_ROUNDS == AES_ROUNDS) ? RND_DRAIN : 4'(N_ROUNDS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SBOX_LATENCY - 1);
    localparam logic [IDX_W-1:0]  REQ_LAST  = IDX_W'(N_REQ - 1);

    logic [SLOT_W-1:0]       slot_ptr_q, slot_ptr_d;
    logic [SBOX_LATENCY-1:0] busy_q, busy_d;
    logic [3:0]              rnd_q [SBOX_LATENCY];
    logic [3:0]              rnd_d [SBOX_LATENCY];
    logic [IDX_W-1:0]        tag_q [SBOX_LATENCY];
    logic [IDX_W-1:0]        tag_d [SBOX_LATENCY];
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0]        gnt_c;
    logic [IDX_W-1:0]        gnt_idx_c;
    logic                    gnt_any_c;

    logic                    cur_busy;
    logic [3:0]              cur_rnd;
    logic [IDX_W-1:0]        cur_tag;
    logic                    slot_free;

    aes_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c),
        .gnt_any_c (gnt_any_c)
    );

    // Visit decode for the slot at slot_ptr, plus next-state for all slot state
    always_comb begin
        slot_ptr_d = (slot_ptr_q == SLOT_LAST) ? '0 : slot_ptr_q + SLOT_W'(1);
        busy_d     = busy_q;
        rnd_d      = rnd_q;
        tag_d      = tag_q;
        rr_ptr_d   = rr_ptr_q;

        req_ready  = '0;
        core_load  = 1'b0;
        core_sel   = '0;
        core_rcon  = 8'h00;
        core_final = 1'b0;
        core_keyen = 1'b0;
        res_valid  = 1'b0;
        res_tag    = '0;

        cur_busy   = busy_q[slot_ptr_q];
        cur_rnd    = rnd_q[slot_ptr_q];
        cur_tag    = tag_q[slot_ptr_q];
        slot_free  = !cur_busy;

        if (cur_busy) begin
            if (cur_rnd == RND_DRN) begin
                // Block has left the final round: report it and free the slot
                res_valid          = 1'b1;
                res_tag            = cur_tag;
                busy_d[slot_ptr_q] = 1'b0;
                slot_free          = 1'b1;
            end else begin
                core_keyen         = 1'b1;
                core_rcon          = rcon(cur_rnd);
                core_final         = (cur_rnd == RND_FIN);
                rnd_d[slot_ptr_q]  = cur_rnd + 4'd1;
            end
        end

        // A slot retiring this visit is refilled in the same cycle
        if (slot_free && gnt_any_c) begin
            req_ready          = gnt_c;
            core_load          = 1'b1;
            core_sel           = gnt_idx_c;
            core_keyen         = 1'b1;
            core_rcon          = rcon(RND_LOAD);
            busy_d[slot_ptr_q] = 1'b1;
            rnd_d[slot_ptr_q]  = RND_LOAD + 4'd1;
            tag_d[slot_ptr_q]  = gnt_idx_c;
            rr_ptr_d           = (gnt_idx_c == REQ_LAST) ? '0 : gnt_idx_c + IDX_W'(1);
        end
    end

    // Slot state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_ptr_q <= '0;
            busy_q     <= '0;
            rr_ptr_q   <= '0;
            for (int unsigned s = 0; s < SBOX_LATENCY; s++) begin
                rnd_q[s] <= '0;
                tag_q[s] <= '0;
            end
        end else begin
            slot_ptr_q <= slot_ptr_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            rnd_q      <= rnd_d;
            tag_q      <= tag_d;
        end
    end

    assign idle = ~|busy_q;

endmodule

// File: tb/tb_aes_slot_scheduler.sv
// Self-checking bench for aes_slot_scheduler (default 5 slots / 4 requesters,
// plus a 1-slot / 1-requester instance).
module tb_aes_slot_scheduler;

    localparam int unsigned LAT = 50;

    typedef struct packed {
        logic [3:0] rdy;
        logic       load;
        logic [1:0] sel;
        logic [7:0] rcon;
        logic       fin;
        logic       keyen;
        logic       res;
        logic [1:0] tag;
        logic       idle;
    } obs_t;

    typedef struct packed {
        logic [3:0] req;
        obs_t       exp;
    } vec_t;

    typedef struct {
        logic [1:0]  tag;
        int unsigned due;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] req_ready;
    logic       core_load;
    logic [1:0] core_sel;
    logic [7:0] core_rcon;
    logic       core_final;
    logic       core_keyen;
    logic       res_valid;
    logic [1:0] res_tag;
    logic       idle;

    logic       rst1 = 1'b1;
    logic [0:0] req1 = '0;
    logic [0:0] rdy1;
    logic       load1;
    logic [0:0] sel1;
    logic [7:0] rcon1;
    logic       fin1;
    logic       key1;
    logic       res1;
    logic [0:0] tag1;
    logic       idle1;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned res_seen = 0;
    sb_t         sbq[$];
    logic [7:0]  rcon_tab [10];
    vec_t        jv [11];
    obs_t        reset_obs;
    obs_t        quiet_obs;

    aes_slot_scheduler #(.SBOX_LATENCY(5), .N_REQ(4), .N_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .core_load(core_load), .core_sel(core_sel), .core_rcon(core_rcon),
        .core_final(core_final), .core_keyen(core_keyen), .res_valid(res_valid),
        .res_tag(res_tag), .idle(idle)
    );

    aes_slot_scheduler #(.SBOX_LATENCY(1), .N_REQ(1), .N_ROUNDS(10)) dut1 (
        .clk(clk), .rst(rst1), .req_valid(req1), .req_ready(rdy1),
        .core_load(load1), .core_sel(sel1), .core_rcon(rcon1),
        .core_final(fin1), .core_keyen(key1), .res_valid(res1),
        .res_tag(tag1), .idle(idle1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.rdy   = req_ready;
        o.load  = core_load;
        o.sel   = core_sel;
        o.rcon  = core_rcon;
        o.fin   = core_final;
        o.keyen = core_keyen;
        o.res   = res_valid;
        o.tag   = res_tag;
        o.idle  = idle;
        return o;
    endfunction

    task automatic expect_load(input logic [1:0] tag);
        sb_t e;
        e.tag = tag;
        e.due = cyc + LAT;
        sbq.push_back(e);
    endtask

    // Result monitor: every res_valid must match the oldest expected load
    always begin
        sb_t e;
        @(negedge clk);
        #3;
        if (!rst && res_valid) begin
            res_seen++;
            if (sbq.size() == 0) begin
                check("sb_unexpected_res", 64'(res_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_tag", 64'(res_tag), 64'(e.tag));
                check("sb_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 64'(sample()), 64'(reset_obs));
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One block from requester 1, visits every 5 cycles, quiet in between
    task automatic run_job_table(input string tname);
        for (int c = 0; c <= 50; c++) begin
            req_valid = (c % 5 == 0) ? jv[c / 5].req : 4'b0000;
            #1;
            if (c % 5 == 0) begin
                if (c == 0) expect_load(2'd1);
                check($sformatf("%s_visit%0d", tname, c / 5), 64'(sample()), 64'(jv[c / 5].exp));
            end else begin
                check($sformatf("%s_quiet%0d", tname, c), 64'(sample()), 64'(quiet_obs));
            end
            @(negedge clk);
        end
        #1;
        check($sformatf("%s_idle_after", tname), 64'(idle), 64'd1);
    endtask

    initial begin
        logic [3:0]  exp_rdy;
        logic        exp_grant;
        logic [1:0]  exp_sel;
        logic        exp_res;
        int unsigned gcount;
        int unsigned seen_before;

        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        reset_obs = '{rdy: 4'b0, load: 1'b0, sel: 2'd0, rcon: 8'h00, fin: 1'b0,
                      keyen: 1'b0, res: 1'b0, tag: 2'd0, idle: 1'b1};
        quiet_obs = '{rdy: 4'b0, load: 1'b0, sel: 2'd0, rcon: 8'h00, fin: 1'b0,
                      keyen: 1'b0, res: 1'b0, tag: 2'd0, idle: 1'b0};
        jv[0] = '{req: 4'b0010, exp: '{rdy: 4'b0010, load: 1'b1, sel: 2'd1, rcon: 8'h01,
                  fin: 1'b0, keyen: 1'b1, res: 1'b0, tag: 2'd0, idle: 1'b1}};
        for (int k = 1; k <= 9; k++) begin
            jv[k] = '{req: 4'b0000, exp: '{rdy: 4'b0, load: 1'b0, sel: 2'd0, rcon: rcon_tab[k],
                      fin: (k == 9), keyen: 1'b1, res: 1'b0, tag: 2'd0, idle: 1'b0}};
        end
        jv[10] = '{req: 4'b0000, exp: '{rdy: 4'b0, load: 1'b0, sel: 2'd0, rcon: 8'h00,
                   fin: 1'b0, keyen: 1'b0, res: 1'b1, tag: 2'd1, idle: 1'b0}};

        // Reset values, then a single job
        do_reset();
        run_job_table("job");

        // Fairness and back-to-back retire+load with all requesters held
        do_reset();
        gcount = 0;
        for (int c = 0; c < 160; c++) begin
            req_valid = (c < 105) ? 4'b1111 : 4'b0000;
            #1;
            exp_grant = (c < 105) && ((c % 50) < 5);
            exp_res   = (c >= 50) && ((c % 50) < 5);
            exp_rdy   = '0;
            exp_sel   = '0;
            if (exp_grant) begin
                exp_sel = 2'(gcount % 4);
                exp_rdy = 4'b0001 << exp_sel;
                expect_load(exp_sel);
                gcount++;
            end
            check($sformatf("fair_grant_c%0d", c), 64'({req_ready, core_load, core_sel}),
                  64'({exp_rdy, exp_grant, exp_sel}));
            check($sformatf("b2b_res_c%0d", c), 64'(res_valid), 64'(exp_res));
            @(negedge clk);
        end
        #1;
        check("drain_idle", 64'(idle), 64'd1);
        check("drain_sb_empty", 64'(sbq.size()), 64'd0);

        // Reset 23 cycles after the third load: in-flight blocks vanish
        do_reset();
        for (int c = 0; c < 25; c++) begin
            req_valid = (c < 3) ? 4'b0111 : 4'b0000;
            #1;
            if (c < 3) check($sformatf("midrst_load%0d", c), 64'(req_ready), 64'(4'b0001 << c));
            @(negedge clk);
        end
        check("midrst_busy_before", 64'(idle), 64'd0);
        rst = 1'b1;
        #1;
        check("midrst_outputs", 64'(sample()), 64'(reset_obs));
        repeat (2) @(negedge clk);
        #1;
        check("midrst_outputs_held", 64'(sample()), 64'(reset_obs));
        @(negedge clk);
        rst = 1'b0;
        seen_before = res_seen;
        for (int c = 0; c < 55; c++) begin
            #1;
            @(negedge clk);
        end
        check("midrst_no_results", 64'(res_seen - seen_before), 64'd0);
        check("midrst_idle", 64'(idle), 64'd1);
        run_job_table("postrst_job");
        check("final_sb_empty", 64'(sbq.size()), 64'd0);

        // One slot, one requester: 10-cycle latency with continuous reload
        @(negedge clk);
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            req1 = 1'b1;
            #1;
            check($sformatf("l1_c%0d", c),
                  64'({rdy1, load1, sel1, rcon1, fin1, key1, res1, tag1}),
                  64'({(c % 10 == 0), (c % 10 == 0), 1'b0, rcon_tab[c % 10],
                       (c % 10 == 9), 1'b1, (c > 0 && c % 10 == 0), 1'b0}));
            @(negedge clk);
        end
        req1 = 1'b0;
        repeat (11) @(negedge clk);
        #1;
        check("l1_idle_after", 64'(idle1), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
